// File: rtl/aidc_lite_code_packer.sv
// aidc_lite_code_packer
// Packs variable-length, MSB-aligned code beats into OUT_W-bit words. Each block
// starts with a PREFIX_W-bit prefix; the final word of a block is zero-padded.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   valid_i      code beat valid         ready_o    beat accepted when valid_i & ready_o
//   sop_i        first beat of block     eop_i      last beat of block (flushes)
//   data_i       code bits, MSB-aligned  size_i     number of valid bits (0..DATA_W)
//   valid_o      output word valid       ready_i    downstream accepts word
//   addr_o       word index in block     data_o     packed word, first bit at MSB
//   last_o       final word of block     done_o     no block in progress
//   blk_bits_o   bits in current block   blk_len_o  bits of last completed block
//   ovf_o        current block exceeded (2**ADDR_W)*OUT_W bits (sticky until sop)
module aidc_lite_code_packer #(
  parameter int unsigned          OUT_W    = 64,
  parameter int unsigned          DATA_W   = 66,
  parameter int unsigned          PREFIX_W = 2,
  parameter logic [PREFIX_W-1:0]  PREFIX   = '0,
  parameter int unsigned          ADDR_W   = 4,
  parameter int unsigned          SZ_W     = $clog2(DATA_W + 1),
  parameter int unsigned          BLK_W    = ADDR_W + $clog2(OUT_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              sop_i,
  input  logic              eop_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [SZ_W-1:0]   size_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [OUT_W-1:0]  data_o,
  output logic              last_o,
  output logic              done_o,
  output logic [BLK_W-1:0]  blk_bits_o,
  output logic [BLK_W-1:0]  blk_len_o,
  output logic              ovf_o
);

  // Merge window: a fill of up to OUT_W-1 bits plus a full beat.
  localparam int unsigned MW        = OUT_W + DATA_W;
  localparam int unsigned FW        = $clog2(MW + 1);
  localparam int unsigned MAX_BLK   = (2 ** ADDR_W) * OUT_W;
  localparam int unsigned BLK_MAXI  = (2 ** BLK_W) - 1;

  localparam logic [FW-1:0]    OUT_F    = FW'(OUT_W);
  localparam logic [FW-1:0]    TWO_OUTF = FW'(2 * OUT_W);
  localparam logic [FW-1:0]    PREFIX_F = FW'(PREFIX_W);
  localparam logic [BLK_W-1:0] PREFIX_B = BLK_W'(PREFIX_W);
  localparam logic [MW-1:0]    ACC_INIT = {PREFIX, {(MW - PREFIX_W){1'b0}}};

  typedef enum logic [0:0] {StRun, StFlush} state_t;

  state_t              st;
  logic [MW-1:0]       acc;
  logic [FW-1:0]       fill;
  logic [ADDR_W-1:0]   word_cnt;
  logic                eop_pend;

  logic                slot_free;
  logic                accept;
  logic [DATA_W-1:0]   data_m;
  logic [MW-1:0]       merged;
  logic [MW-1:0]       rem;
  logic [FW-1:0]       n;
  logic [31:0]         bits_sum;
  logic [BLK_W-1:0]    bits_sat;
  logic                bits_ovf;

  assign slot_free = ~valid_o | ready_i;
  assign ready_o   = (st == StRun) & slot_free;
  assign accept    = valid_i & ready_o;

  always_comb begin
    // Keep only the top size_i bits of the beat.
    data_m   = data_i & ~({DATA_W{1'b1}} >> size_i);
    merged   = acc | ({data_m, {OUT_W{1'b0}}} >> fill);
    rem      = merged << OUT_W;
    n        = fill + FW'(size_i);
    bits_sum = 32'(blk_bits_o) + 32'(size_i);
    bits_sat = (bits_sum > BLK_MAXI) ? {BLK_W{1'b1}} : bits_sum[BLK_W-1:0];
    bits_ovf = (bits_sum > MAX_BLK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= StRun;
      acc        <= ACC_INIT;
      fill       <= PREFIX_F;
      word_cnt   <= '0;
      eop_pend   <= 1'b0;
      valid_o    <= 1'b0;
      data_o     <= '0;
      addr_o     <= '0;
      last_o     <= 1'b0;
      done_o     <= 1'b1;
      blk_bits_o <= PREFIX_B;
      blk_len_o  <= '0;
      ovf_o      <= 1'b0;
    end else begin
      if (valid_o && ready_i) begin
        valid_o <= 1'b0;
        if (last_o) done_o <= 1'b1;
      end

      unique case (st)
        StRun: begin
          if (accept) begin
            // A new block clears done and restarts overflow tracking.
            if (sop_i) begin
              done_o <= 1'b0;
              ovf_o  <= bits_ovf;
            end else if (bits_ovf) begin
              ovf_o <= 1'b1;
            end

            if (eop_i) begin
              blk_len_o  <= bits_sat;
              blk_bits_o <= PREFIX_B;
              valid_o    <= 1'b1;
              data_o     <= merged[MW-1 -: OUT_W];
              addr_o     <= word_cnt;
              if (n <= OUT_F) begin
                last_o   <= 1'b1;
                word_cnt <= '0;
                acc      <= ACC_INIT;
                fill     <= PREFIX_F;
              end else begin
                last_o   <= 1'b0;
                word_cnt <= word_cnt + 1'b1;
                acc      <= rem;
                fill     <= n - OUT_F;
                eop_pend <= 1'b1;
                st       <= StFlush;
              end
            end else begin
              blk_bits_o <= bits_sat;
              if (n < OUT_F) begin
                acc  <= merged;
                fill <= n;
              end else begin
                valid_o  <= 1'b1;
                data_o   <= merged[MW-1 -: OUT_W];
                addr_o   <= word_cnt;
                last_o   <= 1'b0;
                word_cnt <= word_cnt + 1'b1;
                acc      <= rem;
                fill     <= n - OUT_F;
                eop_pend <= 1'b0;
                // A remainder of a full word or more needs a second emit cycle.
                if (n >= TWO_OUTF) st <= StFlush;
              end
            end
          end
        end

        StFlush: begin
          if (slot_free) begin
            valid_o <= 1'b1;
            data_o  <= acc[MW-1 -: OUT_W];
            addr_o  <= word_cnt;
            if (eop_pend && (fill <= OUT_F)) begin
              last_o   <= 1'b1;
              word_cnt <= '0;
              acc      <= ACC_INIT;
              fill     <= PREFIX_F;
              eop_pend <= 1'b0;
              st       <= StRun;
            end else begin
              last_o   <= 1'b0;
              word_cnt <= word_cnt + 1'b1;
              acc      <= acc << OUT_W;
              fill     <= fill - OUT_F;
              if (!eop_pend && (fill < TWO_OUTF)) st <= StRun;
            end
          end
        end

        default: st <= StRun;
      endcase
    end
  end

endmodule

// File: tb/tb_aidc_lite_code_packer.sv
module tb_aidc_lite_code_packer;

  localparam int OUT_W    = 64;
  localparam int DATA_W   = 66;
  localparam int PREFIX_W = 2;
  localparam int ADDR_W   = 4;
  localparam int SZ_W     = 7;
  localparam int BLK_W    = 11;
  localparam int MAXB     = 1024;
  localparam int BLKSAT   = 2047;

  typedef struct packed {
    logic [OUT_W-1:0]  d;
    logic [ADDR_W-1:0] a;
    logic              l;
  } word_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_i, ready_o, sop_i, eop_i;
  logic [DATA_W-1:0] data_i;
  logic [SZ_W-1:0]   size_i;
  logic              valid_o, ready_i;
  logic [ADDR_W-1:0] addr_o;
  logic [OUT_W-1:0]  data_o;
  logic              last_o, done_o, ovf_o;
  logic [BLK_W-1:0]  blk_bits_o, blk_len_o;

  int n_tests = 0;
  int n_fail  = 0;

  aidc_lite_code_packer #(
    .OUT_W(64), .DATA_W(66), .PREFIX_W(2), .PREFIX(2'b00), .ADDR_W(4)
  ) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .sop_i(sop_i),
    .eop_i(eop_i), .data_i(data_i), .size_i(size_i), .valid_o(valid_o),
    .ready_i(ready_i), .addr_o(addr_o), .data_o(data_o), .last_o(last_o),
    .done_o(done_o), .blk_bits_o(blk_bits_o), .blk_len_o(blk_len_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  // Reference model: the block is a plain bit queue, words are cut from its head.
  bit          mq[$];
  word_t       exp_q[$];
  word_t       obs_q[$];
  logic [3:0]  m_addr;
  int          m_bits, m_len;
  logic        m_ovf;
  logic        acc_flag;
  logic        rand_ready = 1'b0;

  function automatic void model_new_block();
    mq.delete();
    for (int i = 0; i < PREFIX_W; i++) mq.push_back(1'b0);
    m_addr = 4'd0;
    m_bits = PREFIX_W;
  endfunction

  function automatic logic [OUT_W-1:0] pop_word();
    logic [OUT_W-1:0] w = '0;
    for (int j = 0; j < OUT_W; j++) if (mq.size() > 0) w[OUT_W-1-j] = mq.pop_front();
    return w;
  endfunction

  function automatic void model_accept(logic sop, logic eop, logic [DATA_W-1:0] d, int sz);
    int    sum;
    int    nw;
    word_t w;
    if (sop) m_ovf = 1'b0;
    sum = m_bits + sz;
    if (sum > MAXB) m_ovf = 1'b1;
    if (sum > BLKSAT) sum = BLKSAT;
    for (int i = 0; i < sz; i++) mq.push_back(d[DATA_W-1-i]);
    if (eop) begin
      nw = (mq.size() + OUT_W - 1) / OUT_W;
      for (int k = 0; k < nw; k++) begin
        w.d = pop_word(); w.a = m_addr; w.l = (k == nw - 1);
        exp_q.push_back(w);
        m_addr = m_addr + 4'd1;
      end
      m_len = sum;
      model_new_block();
    end else begin
      while (mq.size() >= OUT_W) begin
        w.d = pop_word(); w.a = m_addr; w.l = 1'b0;
        exp_q.push_back(w);
        m_addr = m_addr + 4'd1;
      end
      m_bits = sum;
    end
  endfunction

  function automatic void clear_model();
    obs_q.delete();
    exp_q.delete();
    model_new_block();
  endfunction

  function automatic logic [DATA_W-1:0] rand66();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[DATA_W-1:0];
  endfunction

  // One clock: sample at negedge, record handshakes, return 1 time unit after posedge.
  task automatic step();
    word_t w;
    if (rand_ready) ready_i = 1'($urandom_range(0, 1));
    @(negedge clk);
    acc_flag = valid_i && ready_o;
    if (valid_o && ready_i) begin
      w.d = data_o; w.a = addr_o; w.l = last_o;
      obs_q.push_back(w);
    end
    if (acc_flag) model_accept(sop_i, eop_i, data_i, int'(size_i));
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic sop, input logic eop, input logic [DATA_W-1:0] d,
                           input int sz);
    int t = 0;
    sop_i = sop; eop_i = eop; data_i = d; size_i = SZ_W'(sz); valid_i = 1'b1;
    acc_flag = 1'b0;
    while (!acc_flag && t < 200) begin step(); t++; end
    if (!acc_flag) begin
      n_tests++; n_fail++;
      $display("FAIL beat_accept_timeout: beat not accepted after %0d cycles, required accept", t);
    end
    valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    valid_i = 1'b0; rand_ready = 1'b0; ready_i = 1'b1;
    while ((valid_o || !ready_o) && t < 200) begin step(); t++; end
    if (valid_o || !ready_o) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: valid_o=%0b ready_o=%0b, required 0/1", valid_o, ready_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 0; sop_i = 0; eop_i = 0; data_i = '0; size_i = '0; ready_i = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_tests += 9;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", valid_o); end
    if (done_o !== 1'b1) begin n_fail++; $display("FAIL rst_done: got %b want 1", done_o); end
    if (blk_bits_o !== 11'd2) begin n_fail++; $display("FAIL rst_blk_bits: got %0d want 2", blk_bits_o); end
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", ready_o); end
    if (addr_o !== 4'd0) begin n_fail++; $display("FAIL rst_addr: got %0d want 0", addr_o); end
    if (data_o !== '0) begin n_fail++; $display("FAIL rst_data: got %h want 0", data_o); end
    if (last_o !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %b want 0", last_o); end
    if (blk_len_o !== 11'd0) begin n_fail++; $display("FAIL rst_blk_len: got %0d want 0", blk_len_o); end
    if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", ovf_o); end
    m_len = 0; m_ovf = 1'b0;
    clear_model();
  endtask

  task automatic test_basic();
    logic [DATA_W-1:0] d0, d1, d2, d3;
    logic [OUT_W-1:0]  e;
    d0 = rand66(); d1 = rand66(); d2 = rand66(); d3 = rand66();
    clear_model(); ready_i = 1'b1;
    send_beat(1'b1, 1'b0, d0, 6);
    n_tests++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_beat1_word: valid_o=%b want 0", valid_o); end
    send_beat(1'b0, 1'b0, d1, 34);
    n_tests += 2;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_beat2_word: valid_o=%b want 0", valid_o); end
    if (blk_bits_o !== 11'd42) begin n_fail++; $display("FAIL basic_bits42: got %0d want 42", blk_bits_o); end
    send_beat(1'b0, 1'b0, d2, 34);
    e = {2'b00, d0[65:60], d1[65:32], d2[65:44]};
    n_tests += 6;
    if (valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_w0_valid: got %b want 1", valid_o); end
    if (addr_o !== 4'd0) begin n_fail++; $display("FAIL basic_w0_addr: got %0d want 0", addr_o); end
    if (data_o !== e) begin n_fail++; $display("FAIL basic_w0_data: got %h want %h", data_o, e); end
    if (last_o !== 1'b0) begin n_fail++; $display("FAIL basic_w0_last: got %b want 0", last_o); end
    if (blk_bits_o !== 11'd76) begin n_fail++; $display("FAIL basic_bits76: got %0d want 76", blk_bits_o); end
    if (done_o !== 1'b0) begin n_fail++; $display("FAIL basic_done0: got %b want 0", done_o); end
    send_beat(1'b0, 1'b1, d3, 10);
    e = {d2[43:32], d3[65:56], 42'b0};
    n_tests += 6;
    if (valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_w1_valid: got %b want 1", valid_o); end
    if (last_o !== 1'b1) begin n_fail++; $display("FAIL basic_w1_last: got %b want 1", last_o); end
    if (addr_o !== 4'd1) begin n_fail++; $display("FAIL basic_w1_addr: got %0d want 1", addr_o); end
    if (data_o !== e) begin n_fail++; $display("FAIL basic_w1_data: got %h want %h", data_o, e); end
    if (blk_len_o !== 11'd86) begin n_fail++; $display("FAIL basic_blk_len: got %0d want 86", blk_len_o); end
    if (blk_bits_o !== 11'd2) begin n_fail++; $display("FAIL basic_bits_reset: got %0d want 2", blk_bits_o); end
    step();
    n_tests += 2;
    if (done_o !== 1'b1) begin n_fail++; $display("FAIL basic_done1: got %b want 1", done_o); end
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_idle: valid_o=%b want 0", valid_o); end
  endtask

  task automatic test_flush();
    logic [DATA_W-1:0] e0, e1;
    logic [OUT_W-1:0]  e;
    e0 = rand66(); e1 = rand66();
    clear_model(); ready_i = 1'b1;
    send_beat(1'b1, 1'b0, e0, 58);
    send_beat(1'b0, 1'b1, e1, 20);
    e = {2'b00, e0[65:8], e1[65:62]};
    n_tests += 5;
    if (valid_o !== 1'b1) begin n_fail++; $display("FAIL flush_w0_valid: got %b want 1", valid_o); end
    if (addr_o !== 4'd0) begin n_fail++; $display("FAIL flush_w0_addr: got %0d want 0", addr_o); end
    if (last_o !== 1'b0) begin n_fail++; $display("FAIL flush_w0_last: got %b want 0", last_o); end
    if (ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_ready_low: got %b want 0", ready_o); end
    if (data_o !== e) begin n_fail++; $display("FAIL flush_w0_data: got %h want %h", data_o, e); end
    step();
    e = {e1[61:46], 48'b0};
    n_tests += 5;
    if (valid_o !== 1'b1) begin n_fail++; $display("FAIL flush_w1_valid: got %b want 1", valid_o); end
    if (addr_o !== 4'd1) begin n_fail++; $display("FAIL flush_w1_addr: got %0d want 1", addr_o); end
    if (last_o !== 1'b1) begin n_fail++; $display("FAIL flush_w1_last: got %b want 1", last_o); end
    if (data_o !== e) begin n_fail++; $display("FAIL flush_w1_data: got %h want %h", data_o, e); end
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_ready_back: got %b want 1", ready_o); end
    step();
    n_tests++;
    if (done_o !== 1'b1) begin n_fail++; $display("FAIL flush_done: got %b want 1", done_o); end
  endtask

  task automatic test_stall();
    logic [DATA_W-1:0] a1;
    clear_model(); ready_i = 1'b0;
    a1 = rand66();
    send_beat(1'b1, 1'b0, rand66(), 66);
    sop_i = 1'b0; eop_i = 1'b0; data_i = a1; size_i = 7'd66; valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      n_tests += 4;
      if (ready_o !== 1'b0) begin n_fail++; $display("FAIL stall_ready c%0d: got %b want 0", c, ready_o); end
      if (valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_valid c%0d: got %b want 1", c, valid_o); end
      if (data_o !== exp_q[0].d) begin
        n_fail++; $display("FAIL stall_data c%0d: got %h want %h", c, data_o, exp_q[0].d);
      end
      if (addr_o !== exp_q[0].a) begin
        n_fail++; $display("FAIL stall_addr c%0d: got %0d want %0d", c, addr_o, exp_q[0].a);
      end
    end
    ready_i = 1'b1;
    send_beat(1'b0, 1'b0, a1, 66);
    send_beat(1'b0, 1'b0, rand66(), 50);
    send_beat(1'b0, 1'b1, rand66(), 66);
    drain();
    n_tests += 3;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL stall_count: got %0d words want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL stall_word%0d: got %h/%0d/%b want %h/%0d/%b", i, obs_q[i].d, obs_q[i].a,
                 obs_q[i].l, exp_q[i].d, exp_q[i].a, exp_q[i].l);
      end
    end
    if (blk_len_o !== 11'd250) begin n_fail++; $display("FAIL stall_blk_len: got %0d want 250", blk_len_o); end
    if (done_o !== 1'b1) begin n_fail++; $display("FAIL stall_done: got %b want 1", done_o); end
  endtask

  task automatic test_ovf_wrap();
    clear_model(); ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send_beat(i == 0, 1'b0, rand66(), 66);
      if (i == 14) begin
        n_tests += 2;
        if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL ovf_before: got %b want 0", ovf_o); end
        if (blk_bits_o !== 11'd992) begin n_fail++; $display("FAIL ovf_bits992: got %0d want 992", blk_bits_o); end
      end
    end
    n_tests += 2;
    if (ovf_o !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", ovf_o); end
    if (blk_bits_o !== 11'd1058) begin n_fail++; $display("FAIL ovf_bits1058: got %0d want 1058", blk_bits_o); end
    send_beat(1'b0, 1'b1, rand66(), 0);
    n_tests += 2;
    if (ovf_o !== 1'b1) begin n_fail++; $display("FAIL ovf_hold_eop: got %b want 1", ovf_o); end
    if (blk_len_o !== 11'd1058) begin n_fail++; $display("FAIL ovf_blk_len: got %0d want 1058", blk_len_o); end
    drain();
    n_tests += 2;
    if (obs_q[15].a !== 4'd15) begin n_fail++; $display("FAIL wrap_addr15: got %0d want 15", obs_q[15].a); end
    if (obs_q[16].a !== 4'd0) begin n_fail++; $display("FAIL wrap_addr0: got %0d want 0", obs_q[16].a); end
    for (int i = 0; i < 32; i++) begin
      send_beat(i == 0, 1'b0, rand66(), 66);
      if (i == 0) begin
        n_tests++;
        if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL ovf_clear_sop: got %b want 0", ovf_o); end
      end
    end
    n_tests += 2;
    if (blk_bits_o !== 11'd2047) begin n_fail++; $display("FAIL bits_saturate: got %0d want 2047", blk_bits_o); end
    if (ovf_o !== 1'b1) begin n_fail++; $display("FAIL ovf_set2: got %b want 1", ovf_o); end
    send_beat(1'b0, 1'b1, rand66(), 5);
    drain();
    n_tests += 2;
    if (blk_len_o !== 11'd2047) begin n_fail++; $display("FAIL len_saturate: got %0d want 2047", blk_len_o); end
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL ovf_count: got %0d words want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ovf_word%0d: got %h/%0d/%b want %h/%0d/%b", i, obs_q[i].d, obs_q[i].a,
                 obs_q[i].l, exp_q[i].d, exp_q[i].a, exp_q[i].l);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] q;
    logic [OUT_W-1:0]  e;
    clear_model(); ready_i = 1'b0;
    send_beat(1'b1, 1'b0, rand66(), 36);
    send_beat(1'b0, 1'b0, rand66(), 66);
    n_tests++;
    if (valid_o !== 1'b1) begin n_fail++; $display("FAIL rmid_held: valid_o=%b want 1", valid_o); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests += 7;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", valid_o); end
    if (done_o !== 1'b1) begin n_fail++; $display("FAIL rmid_done: got %b want 1", done_o); end
    if (blk_bits_o !== 11'd2) begin n_fail++; $display("FAIL rmid_bits: got %0d want 2", blk_bits_o); end
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", ready_o); end
    if (addr_o !== 4'd0) begin n_fail++; $display("FAIL rmid_addr: got %0d want 0", addr_o); end
    if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL rmid_ovf: got %b want 0", ovf_o); end
    if (blk_len_o !== 11'd0) begin n_fail++; $display("FAIL rmid_len: got %0d want 0", blk_len_o); end
    m_len = 0; m_ovf = 1'b0;
    clear_model();
    ready_i = 1'b1;
    q = rand66();
    send_beat(1'b1, 1'b1, q, 10);
    e = {2'b00, q[65:56], 52'b0};
    n_tests += 3;
    if (data_o !== e) begin n_fail++; $display("FAIL rmid_fresh_data: got %h want %h", data_o, e); end
    if (addr_o !== 4'd0) begin n_fail++; $display("FAIL rmid_fresh_addr: got %0d want 0", addr_o); end
    if (last_o !== 1'b1) begin n_fail++; $display("FAIL rmid_fresh_last: got %b want 1", last_o); end
    step();
    clear_model();
  endtask

  task automatic test_random();
    int nb, sz;
    clear_model();
    rand_ready = 1'b1;
    for (int b = 0; b < 40; b++) begin
      nb = $urandom_range(1, 6);
      for (int k = 0; k < nb; k++) begin
        if ($urandom_range(0, 3) == 0) sz = $urandom_range(0, 1) ? 66 : 0;
        else sz = $urandom_range(0, 66);
        send_beat(k == 0, k == nb - 1, rand66(), sz);
        n_tests += 2;
        if (blk_bits_o !== BLK_W'(m_bits)) begin
          n_fail++; $display("FAIL rnd_bits b%0d: got %0d want %0d", b, blk_bits_o, m_bits);
        end
        if (ovf_o !== m_ovf) begin
          n_fail++; $display("FAIL rnd_ovf b%0d: got %b want %b", b, ovf_o, m_ovf);
        end
      end
      n_tests++;
      if (blk_len_o !== BLK_W'(m_len)) begin
        n_fail++; $display("FAIL rnd_len b%0d: got %0d want %0d", b, blk_len_o, m_len);
      end
      repeat ($urandom_range(0, 2)) step();
    end
    drain();
    n_tests += 2;
    if (done_o !== 1'b1) begin n_fail++; $display("FAIL rnd_done: got %b want 1", done_o); end
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rnd_count: got %0d words want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rnd_word%0d: got %h/%0d/%b want %h/%0d/%b", i, obs_q[i].d, obs_q[i].a,
                 obs_q[i].l, exp_q[i].d, exp_q[i].a, exp_q[i].l);
      end
    end
  endtask

  initial begin
    rst = 1'b1; valid_i = 0; sop_i = 0; eop_i = 0; data_i = '0; size_i = '0; ready_i = 0;
    m_len = 0; m_ovf = 1'b0; acc_flag = 1'b0;
    model_new_block();
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_flush();
    test_stall();
    test_ovf_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
